// File: rtl/mt_perf_monitor_pkg.sv
// Shared types and constants for the multi-thread performance monitor.
// A lane thread ID at or above the thread count marks that lane as idle.
package mt_perf_monitor_pkg;

  localparam int TID_W = 3;
  localparam int NUM_ALUs = 3;
  localparam int NUM_ALUS_DEF = NUM_ALUs;
  localparam int NUM_THREADS_DEF = 4;
  localparam logic [TID_W-1:0] TID_IDLE = 3'd7;

  typedef enum logic [1:0] {
    TS_WAIT,
    TS_SETTLE,
    TS_PASS,
    TS_FAIL
  } thr_state_e;

  typedef enum logic {
    GS_RUN,
    GS_HALT
  } glb_state_e;

  function automatic logic tid_active(input logic [TID_W-1:0] tid, input int num_threads);
    return 32'(tid) < num_threads;
  endfunction

endpackage

// File: rtl/mt_perf_monitor_verdict.sv
// Per-thread verdict FSM: waits for done, settles, then samples pass.
// Exposes its state for the top level and for external checkers.
module mt_thread_verdict
  import mt_perf_monitor_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             done_i,
  input  logic             pass_i,
  input  logic             force_fail_i,
  input  logic [CNT_W-1:0] cycle_count_i,
  output thr_state_e       state_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] cycles_o
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  thr_state_e       state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             pass_q, fail_q;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    cycles_d = cycles_q;
    case (state_q)
      TS_WAIT: begin
        // A forced fail wins over a done arriving on the same edge.
        if (force_fail_i) begin
          state_d = TS_FAIL;
        end else if (done_i) begin
          state_d  = TS_SETTLE;
          settle_d = SETTLE_LOAD;
          cycles_d = cycle_count_i;
        end
      end
      TS_SETTLE: begin
        // The sampled verdict wins over a forced fail on the same edge.
        if (settle_q == 4'd0) begin
          state_d = pass_i ? TS_PASS : TS_FAIL;
        end else begin
          settle_d = settle_q - 4'd1;
          if (force_fail_i) state_d = TS_FAIL;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= TS_WAIT;
      settle_q <= '0;
      cycles_q <= '0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else if (clr_i) begin
      state_q  <= TS_WAIT;
      settle_q <= '0;
      cycles_q <= '0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      cycles_q <= cycles_d;
      pass_q   <= (state_d == TS_PASS);
      fail_q   <= (state_d == TS_FAIL);
    end
  end

  assign state_o  = state_q;
  assign pass_o   = pass_q;
  assign fail_o   = fail_q;
  assign cycles_o = cycles_q;

endmodule

// File: rtl/mt_perf_monitor.sv
// Per-thread completion and performance monitor: global RUN/HALT FSM, issue
// popcount and saturating counters. MT_PERF_THREAD_INST_EN adds per-thread issue counts.
module mt_perf_monitor
  import mt_perf_monitor_pkg::*;
#(
  parameter int NUM_THREADS    = NUM_THREADS_DEF,
  parameter int NUM_ALUS       = NUM_ALUS_DEF,
  parameter int CNT_W          = 32,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic [NUM_ALUS*TID_W-1:0]    dispatch_tid_i,
  input  logic [NUM_THREADS-1:0]       done_i,
  input  logic [NUM_THREADS-1:0]       pass_i,
  output logic [NUM_THREADS-1:0]       thread_pass_o,
  output logic [NUM_THREADS-1:0]       thread_fail_o,
  output logic                         timeout_o,
  output logic                         all_done_o,
  output logic                         all_pass_o,
  output logic [CNT_W-1:0]             cycle_count_o,
  output logic [CNT_W-1:0]             inst_count_o,
  output logic [NUM_THREADS*CNT_W-1:0] thread_cycles_o
`ifdef MT_PERF_THREAD_INST_EN
  ,
  output logic [NUM_THREADS*CNT_W-1:0] thread_inst_o
`endif
);

  localparam int SUM_W = $clog2(NUM_ALUS + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(TIMEOUT_CYCLES - 1);

  glb_state_e             gstate_q, gstate_d;
  logic [CNT_W-1:0]       cycle_q, cycle_d;
  logic [CNT_W-1:0]       inst_q, inst_d;
  logic [CNT_W:0]         inst_sum;
  logic [SUM_W-1:0]       lane_sum;
  logic                   timeout_q, all_done_q, all_pass_q;
  logic                   run, timeout_hit, all_resolved;
  thr_state_e             thr_state [NUM_THREADS];
  logic [NUM_THREADS-1:0] thr_pass, thr_fail, thr_resolved;

  assign run = (gstate_q == GS_RUN);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && run && (cycle_q == TIMEOUT_AT);

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
    mt_thread_verdict #(
      .CNT_W        (CNT_W),
      .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_verdict (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (clr_i),
      .done_i       (done_i[t]),
      .pass_i       (pass_i[t]),
      .force_fail_i (timeout_hit),
      .cycle_count_i(cycle_q),
      .state_o      (thr_state[t]),
      .pass_o       (thr_pass[t]),
      .fail_o       (thr_fail[t]),
      .cycles_o     (thread_cycles_o[t*CNT_W +: CNT_W])
    );
    assign thr_resolved[t] = (thr_state[t] == TS_PASS) || (thr_state[t] == TS_FAIL);
  end

  assign all_resolved = &thr_resolved;

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < NUM_ALUS; l++) begin
      if (tid_active(dispatch_tid_i[l*TID_W +: TID_W], NUM_THREADS)) begin
        lane_sum = lane_sum + SUM_W'(1);
      end
    end
  end

  always_comb begin
    gstate_d = gstate_q;
    cycle_d  = cycle_q;
    inst_d   = inst_q;
    inst_sum = {1'b0, inst_q} + (CNT_W + 1)'(lane_sum);
    if (run) begin
      if (all_resolved) gstate_d = GS_HALT;
      if (cycle_q != '1) cycle_d = cycle_q + CNT_W'(1);
      inst_d = inst_sum[CNT_W] ? '1 : inst_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gstate_q   <= GS_RUN;
      cycle_q    <= '0;
      inst_q     <= '0;
      timeout_q  <= 1'b0;
      all_done_q <= 1'b0;
      all_pass_q <= 1'b0;
    end else if (clr_i) begin
      gstate_q   <= GS_RUN;
      cycle_q    <= '0;
      inst_q     <= '0;
      timeout_q  <= 1'b0;
      all_done_q <= 1'b0;
      all_pass_q <= 1'b0;
    end else begin
      gstate_q   <= gstate_d;
      cycle_q    <= cycle_d;
      inst_q     <= inst_d;
      timeout_q  <= timeout_q | timeout_hit;
      all_done_q <= (gstate_d == GS_HALT);
      // Verdicts are already final by the time HALT is entered.
      all_pass_q <= (gstate_d == GS_HALT) & ~|thr_fail;
    end
  end

  assign thread_pass_o = thr_pass;
  assign thread_fail_o = thr_fail;
  assign timeout_o     = timeout_q;
  assign all_done_o    = all_done_q;
  assign all_pass_o    = all_pass_q;
  assign cycle_count_o = cycle_q;
  assign inst_count_o  = inst_q;

`ifdef MT_PERF_THREAD_INST_EN
  logic [CNT_W-1:0] tinst_q [NUM_THREADS];
  logic [CNT_W-1:0] tinst_d [NUM_THREADS];
  logic [SUM_W-1:0] tlane   [NUM_THREADS];
  logic [CNT_W:0]   tsum    [NUM_THREADS];

  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      tlane[t] = '0;
      for (int l = 0; l < NUM_ALUS; l++) begin
        if (32'(dispatch_tid_i[l*TID_W +: TID_W]) == t) tlane[t] = tlane[t] + SUM_W'(1);
      end
      tsum[t]    = {1'b0, tinst_q[t]} + (CNT_W + 1)'(tlane[t]);
      tinst_d[t] = tinst_q[t];
      if ((thr_state[t] == TS_WAIT) || (thr_state[t] == TS_SETTLE)) begin
        tinst_d[t] = tsum[t][CNT_W] ? '1 : tsum[t][CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < NUM_THREADS; t++) tinst_q[t] <= '0;
    end else if (clr_i) begin
      for (int t = 0; t < NUM_THREADS; t++) tinst_q[t] <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) tinst_q[t] <= tinst_d[t];
    end
  end

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_tinst_out
    assign thread_inst_o[t*CNT_W +: CNT_W] = tinst_q[t];
  end
`endif

endmodule

// File: tb/tb_mt_perf_monitor.sv
// Directed bench for mt_perf_monitor (4 threads, 3 lanes, timeout at 64 cycles).
module tb_mt_perf_monitor;

  localparam int NT = 4;
  localparam int NA = 3;
  localparam int CW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            clr_i = 1'b0;
  logic [NA*3-1:0] dispatch_tid_i = {3'd7, 3'd7, 3'd7};
  logic [NT-1:0]   done_i = '0;
  logic [NT-1:0]   pass_i = '0;
  logic [NT-1:0]   thread_pass_o, thread_fail_o;
  logic            timeout_o, all_done_o, all_pass_o;
  logic [CW-1:0]   cycle_count_o, inst_count_o;
  logic [NT*CW-1:0] thread_cycles_o;
`ifdef MT_PERF_THREAD_INST_EN
  logic [NT*CW-1:0] thread_inst_o;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [CW-1:0] exp_q[$];

  mt_perf_monitor #(
    .NUM_THREADS   (NT),
    .NUM_ALUS      (NA),
    .CNT_W         (CW),
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clr_i          (clr_i),
    .dispatch_tid_i (dispatch_tid_i),
    .done_i         (done_i),
    .pass_i         (pass_i),
    .thread_pass_o  (thread_pass_o),
    .thread_fail_o  (thread_fail_o),
    .timeout_o      (timeout_o),
    .all_done_o     (all_done_o),
    .all_pass_o     (all_pass_o),
    .cycle_count_o  (cycle_count_o),
    .inst_count_o   (inst_count_o),
    .thread_cycles_o(thread_cycles_o)
`ifdef MT_PERF_THREAD_INST_EN
    ,
    .thread_inst_o  (thread_inst_o)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic do_clr();
    clr_i = 1'b1;
    done_i = '0;
    pass_i = '0;
    dispatch_tid_i = {3'd7, 3'd7, 3'd7};
    tick(1);
    clr_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {thread_pass_o, thread_fail_o, timeout_o, all_done_o, all_pass_o}, '0);
    chk({tag, "_cycle"}, cycle_count_o, 0);
    chk({tag, "_inst"}, inst_count_o, 0);
    chk({tag, "_tcyc"}, thread_cycles_o, 0);
  endtask

  initial begin
    // Reset state
    #12;
    chk_all_zero("reset");
    rst = 1'b1;

    // Idle lanes, all threads pass at cycle 10
    tick(10);
    chk("t1_cycle10", cycle_count_o, 10);
    done_i = 4'b1111;
    pass_i = 4'b1111;
    tick(4);
    chk("t1_pass_early", thread_pass_o, 4'h0);
    tick(1);
    chk("t1_pass", thread_pass_o, 4'hF);
    chk("t1_done_early", all_done_o, 1'b0);
    tick(1);
    chk("t1_all_done", all_done_o, 1'b1);
    chk("t1_all_pass", all_pass_o, 1'b1);
    chk("t1_inst", inst_count_o, 0);
    chk("t1_tcyc0", thread_cycles_o[0 +: CW], 10);
    tick(3);
    chk("t1_cycle_frozen", cycle_count_o, 16);

    // Clear in HALT
    do_clr();
    chk_all_zero("clr_halt");
    tick(3);
    chk("clr_restart", cycle_count_o, 3);

    // Lanes {0,1,idle} for 20 cycles
    do_clr();
    dispatch_tid_i = {3'd7, 3'd1, 3'd0};
    tick(20);
    exp_q.push_back(32'd40);
    chk("t2_inst", inst_count_o, exp_q.pop_front());
    chk("t2_cycle", cycle_count_o, 20);
    dispatch_tid_i = {3'd7, 3'd7, 3'd7};
    done_i = 4'b1111;
    pass_i = 4'b1111;
    tick(6);
    exp_q.push_back(32'd40);
    chk("t2_inst_halt", inst_count_o, exp_q.pop_front());
    chk("t2_all_pass", {all_done_o, all_pass_o}, 2'b11);
    chk("t2_cycle_halt", cycle_count_o, 26);
`ifdef MT_PERF_THREAD_INST_EN
    chk("t2_tinst", thread_inst_o, {32'd0, 32'd0, 32'd20, 32'd20});
`endif

    // Thread 2 fails at cycle 30, others pass at cycle 50
    do_clr();
    tick(30);
    done_i = 4'b0100;
    pass_i = 4'b0000;
    tick(20);
    chk("t3_fail_early", thread_fail_o, 4'b0100);
    done_i = 4'b1111;
    pass_i = 4'b1011;
    tick(5);
    chk("t3_pass", thread_pass_o, 4'b1011);
    chk("t3_fail", thread_fail_o, 4'b0100);
    tick(1);
    chk("t3_all_done", all_done_o, 1'b1);
    chk("t3_all_pass", all_pass_o, 1'b0);
    chk("t3_tcyc2", thread_cycles_o[2*CW +: CW], 30);
    chk("t3_tcyc0", thread_cycles_o[0 +: CW], 50);
    chk("t3_no_timeout", timeout_o, 1'b0);

    // One-cycle done pulse on thread 1
    do_clr();
    done_i = 4'b0010;
    pass_i = 4'b0010;
    tick(1);
    done_i = 4'b0000;
    tick(3);
    chk("t4_pulse_early", thread_pass_o, 4'b0000);
    tick(1);
    chk("t4_pulse_pass", thread_pass_o, 4'b0010);
    chk("t4_not_done", all_done_o, 1'b0);

    // Timeout at 64: t0 passes, t1 settles on the timeout edge, t2 mid-settle, t3 waiting
    do_clr();
    done_i = 4'b0001;
    pass_i = 4'b0001;
    tick(59);
    done_i = 4'b0011;
    pass_i = 4'b0011;
    tick(2);
    done_i = 4'b0111;
    pass_i = 4'b0111;
    tick(2);
    chk("t5_cycle63", cycle_count_o, 63);
    chk("t5_pre_timeout", {timeout_o, thread_fail_o}, 5'b0_0000);
    tick(1);
    chk("t5_timeout", timeout_o, 1'b1);
    chk("t5_pass", thread_pass_o, 4'b0011);
    chk("t5_fail", thread_fail_o, 4'b1100);
    chk("t5_tcyc", thread_cycles_o, {32'd0, 32'd61, 32'd59, 32'd0});
    tick(1);
    chk("t5_all_done", {all_done_o, all_pass_o}, 2'b10);
    tick(2);
    chk("t5_cycle_frozen", cycle_count_o, 65);

    // Asynchronous reset mid-settle
    do_clr();
    tick(5);
    done_i = 4'b1111;
    pass_i = 4'b1111;
    tick(2);
    chk("t6_tcyc_pre", thread_cycles_o[3*CW +: CW], 5);
    rst = 1'b0;
    #1;
    chk_all_zero("t6_rst");
    done_i = '0;
    rst = 1'b1;
    tick(6);
    chk("t6_restart", cycle_count_o, 6);
    chk("t6_no_verdict", {thread_pass_o, thread_fail_o}, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
